// File: rtl/merge_tree_pkg.sv
// Shared types for the merge-tree write scheduler.
//   sched_state_t : scheduler FSM encoding
//   BPB           : bytes per beat for the default 512-bit stream width
package merge_tree_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARB,
    CMD,
    DATA,
    DONE
  } sched_state_t;

  localparam int DEF_TDATA_W = 512;
  localparam int BPB         = DEF_TDATA_W / 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr.
//   req : request vector, one bit per channel
//   ptr : highest-priority channel this round
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : index of the granted channel (0 when nothing requests)
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx
);

  // Walk offsets from farthest to nearest so the nearest requester
  // (smallest distance from ptr) is the last write and wins.
  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[IW'(c)]) begin
        gnt          = '0;
        gnt[IW'(c)]  = 1'b1;
        idx          = IW'(c);
      end
    end
  end

endmodule

// File: rtl/merge_tree_write_scheduler.sv
// Shares one AXI write master between NUM_CH merge-tree output streams.
// Each run writes i_num_beats[c] beats per channel starting at
// i_base_addr[c]; channels are served round-robin, one burst at a time.
// Every burst issues one command (addr, beats) followed by exactly that
// many data beats, the last carrying tlast.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_start, o_busy, o_done      : run control / status
//   i_base_addr, i_num_beats     : per-channel run setup, sampled at start
//   s_axis_*                     : per-channel input streams
//   o_cmd_*, i_cmd_ready         : burst command to the write master
//   m_axis_*                     : muxed data stream to the write master
module merge_tree_write_scheduler
  import merge_tree_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int ADDR_WIDTH       = 64,
  parameter int CNT_WIDTH        = 32,
  parameter int BURST_BEATS      = 64
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_start,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]        i_base_addr,
  input  logic [NUM_CH-1:0][CNT_WIDTH-1:0]         i_num_beats,
  output logic                                     o_busy,
  output logic                                     o_done,
  input  logic [NUM_CH-1:0]                        s_axis_tvalid,
  output logic [NUM_CH-1:0]                        s_axis_tready,
  input  logic [NUM_CH-1:0][AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  output logic                                     o_cmd_valid,
  input  logic                                     i_cmd_ready,
  output logic [ADDR_WIDTH-1:0]                    o_cmd_addr,
  output logic [$clog2(BURST_BEATS):0]             o_cmd_beats,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]              m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic                                     m_axis_tlast
);

  localparam int IW        = $clog2(NUM_CH);
  localparam int BW        = $clog2(BURST_BEATS) + 1;
  localparam int BEAT_BYTE = AXIS_TDATA_WIDTH / 8;

  sched_state_t                      state;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  rem;
  logic [IW-1:0]                     ptr, g, idx;
  logic [BW-1:0]                     blen, cnt, blen_nxt;
  logic [NUM_CH-1:0]                 elig, gnt, busy_other;
  logic [CNT_WIDTH-1:0]              rem_g_nxt;
  logic                              dat_phase, m_hs;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign elig[c]       = (rem[c] != '0) && s_axis_tvalid[c];
    // Channels other than the one in flight that still owe beats.
    assign busy_other[c] = (rem[c] != '0) && (g != IW'(c));
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  // Burst never exceeds BURST_BEATS; with an aligned base every burst
  // except a channel's tail is full, so no boundary is ever crossed.
  assign blen_nxt  = (rem[idx] >= CNT_WIDTH'(BURST_BEATS)) ? BW'(BURST_BEATS)
                                                           : rem[idx][BW-1:0];
  assign rem_g_nxt = rem[g] - CNT_WIDTH'(blen);

  // Data phase is a pure pass-through of the granted channel.
  assign dat_phase     = (state == DATA);
  assign m_axis_tvalid = dat_phase & s_axis_tvalid[g];
  assign m_axis_tdata  = s_axis_tdata[g];
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = dat_phase & (cnt == blen - 1'b1);
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (dat_phase) s_axis_tready[g] = m_axis_tready;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd_addr  <= '0;
      o_cmd_beats <= '0;
      ptr         <= '0;
      g           <= '0;
      blen        <= '0;
      cnt         <= '0;
      addr        <= '0;
      rem         <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          addr   <= i_base_addr;
          rem    <= i_num_beats;
          o_busy <= 1'b1;
          state  <= LOAD;
        end
        LOAD: state <= (rem == '0) ? DONE : ARB;
        ARB: if (|gnt) begin
          g           <= idx;
          blen        <= blen_nxt;
          o_cmd_valid <= 1'b1;
          o_cmd_addr  <= addr[idx];
          o_cmd_beats <= blen_nxt;
          state       <= CMD;
        end
        CMD: if (i_cmd_ready) begin
          o_cmd_valid <= 1'b0;
          cnt         <= '0;
          state       <= DATA;
        end
        DATA: if (m_hs) begin
          cnt <= cnt + 1'b1;
          if (m_axis_tlast) begin
            addr[g] <= addr[g] + ADDR_WIDTH'(blen) * ADDR_WIDTH'(BEAT_BYTE);
            rem[g]  <= rem_g_nxt;
            ptr     <= (g == IW'(NUM_CH - 1)) ? '0 : g + 1'b1;
            state   <= (!(|busy_other) && rem_g_nxt == '0) ? DONE : ARB;
          end
        end
        // o_done and the busy drop land together one cycle after DONE.
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_tree_write_scheduler.sv
module tb_merge_tree_write_scheduler;

  localparam int NCH = 4, DW = 512, AW = 64, CW = 32, BB = 64;

  logic                     i_clk = 1'b0;
  logic                     i_rst, i_start, i_cmd_ready;
  logic [NCH-1:0][AW-1:0]   i_base_addr;
  logic [NCH-1:0][CW-1:0]   i_num_beats;
  logic                     o_busy, o_done;
  logic [NCH-1:0]           s_axis_tvalid, s_axis_tready;
  logic [NCH-1:0][DW-1:0]   s_axis_tdata;
  logic                     o_cmd_valid;
  logic [AW-1:0]            o_cmd_addr;
  logic [$clog2(BB):0]      o_cmd_beats;
  logic                     m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0]            m_axis_tdata;
  logic [DW/8-1:0]          m_axis_tkeep;

  merge_tree_write_scheduler #(
    .NUM_CH(NCH), .AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW), .BURST_BEATS(BB)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_num_beats(i_num_beats),
    .o_busy(o_busy), .o_done(o_done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_addr(o_cmd_addr), .o_cmd_beats(o_cmd_beats),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tag(input int c, input int unsigned n);
    return {c[7:0], n[23:0]};
  endfunction

  // ---------------- sources + monitor ----------------
  logic [NCH-1:0]  src_en  = '0;
  bit              rnd_rdy = 0;
  int unsigned     src_idx[NCH];
  logic [NCH-1:0]  pend_s;
  bit              pend_m, pend_c;
  logic [64:0]     pend_beat;
  logic [AW-1:0]   pend_addr;
  int              pend_len;
  logic [64:0]     beat_q[$];
  logic [AW-1:0]   cmd_addr_q[$];
  int              cmd_len_q[$];
  int              done_cnt = 0, ovl_cnt = 0, keep_cnt = 0;

  // Inputs change on the falling edge; handshakes are sampled 1ns before
  // the rising edge and committed to the logs on the next falling edge.
  initial begin
    pend_s = '0; pend_m = 0; pend_c = 0;
    for (int c = 0; c < NCH; c++) src_idx[c] = 0;
    forever begin
      @(negedge i_clk);
      for (int c = 0; c < NCH; c++) if (pend_s[c]) src_idx[c]++;
      if (pend_m) beat_q.push_back(pend_beat);
      if (pend_c) begin
        cmd_addr_q.push_back(pend_addr);
        cmd_len_q.push_back(pend_len);
      end
      m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < NCH; c++) begin
        s_axis_tvalid[c] = src_en[c];
        s_axis_tdata[c]  = {tag(c, src_idx[c]), 448'b0, tag(c, src_idx[c])};
      end
      #4;
      if (i_rst) begin
        pend_s = '0; pend_m = 0; pend_c = 0;
      end else begin
        pend_s    = s_axis_tvalid & s_axis_tready;
        pend_m    = m_axis_tvalid & m_axis_tready;
        pend_beat = {m_axis_tdata[DW-1:DW-32], m_axis_tdata[31:0], m_axis_tlast};
        pend_c    = o_cmd_valid & i_cmd_ready;
        pend_addr = o_cmd_addr;
        pend_len  = int'(o_cmd_beats);
        if (o_done) done_cnt++;
        if (m_axis_tvalid && o_cmd_valid) ovl_cnt++;
        if (m_axis_tvalid && m_axis_tkeep != '1) keep_cnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  int          snap_c, snap_b, snap_d;
  int unsigned snap_idx[NCH];
  int          e_ch[8];
  logic [AW-1:0] e_ad[8];
  int          e_ln[8];

  task automatic tick();
    @(negedge i_clk); #1;
  endtask

  task automatic do_reset();
    tick(); i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;
  endtask

  task automatic snap();
    snap_c = cmd_addr_q.size(); snap_b = beat_q.size(); snap_d = done_cnt;
    for (int c = 0; c < NCH; c++) snap_idx[c] = src_idx[c];
  endtask

  task automatic launch(input logic [NCH-1:0][AW-1:0] b, input logic [NCH-1:0][CW-1:0] n);
    tick(); snap();
    i_base_addr = b; i_num_beats = n; i_start = 1'b1;
    tick(); i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (done_cnt == snap_d && k < budget) begin tick(); k++; end
    chk({nm, "_done_in_time"}, 64'(k < budget), 1);
    tick(); tick();
  endtask

  task automatic set_cmd(input int i, input int ch, input logic [AW-1:0] ad, input int ln);
    e_ch[i] = ch; e_ad[i] = ad; e_ln[i] = ln;
  endtask

  task automatic check_run(input string nm, input int ncmd);
    int used[NCH];
    int bi, errs, tot;
    logic [64:0] bt;
    logic [31:0] et;
    tot = 0;
    for (int c = 0; c < NCH; c++) used[c] = 0;
    for (int i = 0; i < ncmd; i++) tot += e_ln[i];
    chk({nm, "_ncmd"}, 64'(cmd_addr_q.size() - snap_c), 64'(ncmd));
    chk({nm, "_nbeat"}, 64'(beat_q.size() - snap_b), 64'(tot));
    chk({nm, "_ndone"}, 64'(done_cnt - snap_d), 1);
    for (int i = 0; i < ncmd; i++) begin
      if (snap_c + i < cmd_addr_q.size()) begin
        chk($sformatf("%s_cmd%0d_addr", nm, i), cmd_addr_q[snap_c + i], e_ad[i]);
        chk($sformatf("%s_cmd%0d_len", nm, i), 64'(cmd_len_q[snap_c + i]), 64'(e_ln[i]));
      end
    end
    bi = snap_b; errs = 0;
    for (int i = 0; i < ncmd; i++) begin
      for (int j = 0; j < e_ln[i]; j++) begin
        if (bi >= beat_q.size()) errs++;
        else begin
          bt = beat_q[bi];
          et = tag(e_ch[i], snap_idx[e_ch[i]] + used[e_ch[i]]);
          if (bt[64:33] !== et || bt[32:1] !== et || bt[0] !== (j == e_ln[i] - 1)) errs++;
        end
        used[e_ch[i]]++; bi++;
      end
    end
    chk({nm, "_data_tlast_errs"}, 64'(errs), 0);
  endtask

  // ---------------- directed scenarios ----------------
  logic [NCH-1:0][AW-1:0] b;
  logic [NCH-1:0][CW-1:0] n;
  logic [AW-1:0]          a0;
  logic [$clog2(BB):0]    l0;
  logic [3:0]             dpat, bpat;
  int                     k, bp_err;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_cmd_ready = 1'b1;
    i_base_addr = '0; i_num_beats = '0;
    tick(); tick(); tick();
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_ctl", 64'({o_done, o_cmd_valid, m_axis_tvalid, m_axis_tlast}), 0);
    chk("rst_srdy", 64'(s_axis_tready), 0);
    i_rst = 1'b0;

    // single channel, 130 beats -> 64 + 64 + 2
    src_en = 4'b0001;
    for (int c = 0; c < NCH; c++) b[c] = 64'h100000 * (c + 1);
    b[0] = 64'h1000; n = '0; n[0] = 130;
    launch(b, n);
    wait_done("single", 2000);
    set_cmd(0, 0, 64'h1000, 64); set_cmd(1, 0, 64'h2000, 64); set_cmd(2, 0, 64'h3000, 2);
    check_run("single", 3);
    if (beat_q.size() > snap_b + 129) chk("single_tlast_beat129", 64'(beat_q[snap_b + 129][0]), 1);

    // round robin, with a start pulse mid-run that must be ignored
    do_reset();
    src_en = 4'hf;
    for (int c = 0; c < NCH; c++) begin b[c] = 64'h10000 * (c + 1); n[c] = 64; end
    launch(b, n);
    repeat (100) tick();
    i_num_beats = {NCH{32'd5}}; i_base_addr = '0; i_start = 1'b1;
    tick(); i_start = 1'b0;
    wait_done("rr", 3000);
    for (int c = 0; c < NCH; c++) set_cmd(c, c, 64'h10000 * (c + 1), 64);
    check_run("rr", 4);
    repeat (10) tick();
    chk("rr_no_restart", 64'(cmd_addr_q.size() - snap_c), 4);
    chk("rr_idle_busy", 64'(o_busy), 0);

    // starved channel 1
    do_reset();
    src_en = 4'b1101;
    for (int c = 0; c < NCH; c++) begin b[c] = 64'h40000 + 64'h10000 * c; n[c] = 64; end
    launch(b, n);
    k = 0;
    while (beat_q.size() - snap_b < 192 && k < 2000) begin tick(); k++; end
    chk("starve_three_bursts_in_time", 64'(k < 2000), 1);
    repeat (10) tick();
    chk("starve_ncmd", 64'(cmd_addr_q.size() - snap_c), 3);
    chk("starve_wait_state", 64'({o_busy, o_cmd_valid, m_axis_tvalid}), 64'(3'b100));
    src_en = 4'hf;
    wait_done("starve", 2000);
    set_cmd(0, 0, 64'h40000, 64); set_cmd(1, 2, 64'h60000, 64);
    set_cmd(2, 3, 64'h70000, 64); set_cmd(3, 1, 64'h50000, 64);
    check_run("starve", 4);

    // command backpressure, then random data backpressure
    do_reset();
    src_en = 4'hf; i_cmd_ready = 1'b0; rnd_rdy = 1;
    for (int c = 0; c < NCH; c++) b[c] = 64'h80000 + 64'h10000 * c;
    n[0] = 3; n[1] = 70; n[2] = 0; n[3] = 65;
    launch(b, n);
    k = 0;
    while (!o_cmd_valid && k < 20) begin tick(); k++; end
    chk("bp_cmd_valid_in_time", 64'(k < 20), 1);
    a0 = o_cmd_addr; l0 = o_cmd_beats;
    chk("bp_first_addr", a0, 64'h80000);
    chk("bp_first_len", 64'(l0), 3);
    bp_err = 0;
    repeat (5) begin
      tick();
      if (!o_cmd_valid || o_cmd_addr !== a0 || o_cmd_beats !== l0 || m_axis_tvalid) bp_err++;
    end
    chk("bp_hold_errs", 64'(bp_err), 0);
    chk("bp_no_beats", 64'(beat_q.size() - snap_b), 0);
    i_cmd_ready = 1'b1;
    wait_done("bp", 5000);
    rnd_rdy = 0;
    set_cmd(0, 0, 64'h80000, 3);  set_cmd(1, 1, 64'h90000, 64);
    set_cmd(2, 3, 64'hB0000, 64); set_cmd(3, 1, 64'h91000, 6);
    set_cmd(4, 3, 64'hB1000, 1);
    check_run("bp", 5);

    // all-zero run: o_done three cycles after the start cycle
    tick(); snap();
    i_num_beats = '0; i_start = 1'b1;
    tick(); i_start = 1'b0;
    for (int j = 0; j < 4; j++) begin dpat[j] = o_done; bpat[j] = o_busy; tick(); end
    chk("zero_done_pattern", 64'(dpat), 64'(4'b0100));
    chk("zero_busy_pattern", 64'(bpat), 64'(4'b0011));
    chk("zero_no_cmd", 64'(cmd_addr_q.size() - snap_c), 0);
    chk("zero_ndone", 64'(done_cnt - snap_d), 1);

    // reset at beat 10 of a 64-beat burst
    do_reset();
    src_en = 4'b0001;
    b = '0; b[0] = 64'hC0000; n = '0; n[0] = 64;
    launch(b, n);
    k = 0;
    while (beat_q.size() - snap_b < 10 && k < 200) begin tick(); k++; end
    chk("midrst_reach_beat10", 64'(k < 200), 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("midrst_ctl", 64'({o_busy, o_done, o_cmd_valid, m_axis_tvalid, m_axis_tlast}), 0);
    chk("midrst_srdy", 64'(s_axis_tready), 0);
    tick(); i_rst = 1'b0;
    repeat (5) tick();
    chk("midrst_no_done", 64'(done_cnt - snap_d), 0);
    chk("midrst_beats", 64'(beat_q.size() - snap_b), 10);
    launch(b, n);
    wait_done("fresh", 1000);
    set_cmd(0, 0, 64'hC0000, 64);
    check_run("fresh", 1);

    chk("cmd_data_overlap", 64'(ovl_cnt), 0);
    chk("tkeep_errs", 64'(keep_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
